// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter feeding one shared UART transmitter
// Optional WAIT-state timeout: define UART_ARB_TIMEOUT_EN (err is tied 0 otherwise).
module uart_tx_arb #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_done,
  output logic                    arb_busy,
  output logic                    err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   sel_q;
  logic [IDX_W-1:0]   sel_d;
  logic [IDX_W-1:0]   last_q;
  logic [DATA_W-1:0]  tx_data_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               found;
  int                 rr_idx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
`endif

  // Round-robin pick: first pending requester after the last one granted.
  always_comb begin
    sel_d  = last_q;
    found  = 1'b0;
    rr_idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_idx = (int'(last_q) + k) % N_REQ;
      if (!found && req[rr_idx]) begin
        sel_d = IDX_W'(rr_idx);
        found = 1'b1;
      end
    end
  end

  // Arbitration FSM; all outputs are registered and pulse outputs default low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      last_q     <= IDX_W'(N_REQ - 1);
      tx_data_q  <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      gnt_q      <= '0;
      done_q     <= '0;
      tx_start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (|req) begin
            // Winner and its byte are frozen here; req changes later are ignored.
            sel_q      <= sel_d;
            tx_data_q  <= req_data[int'(sel_d)*DATA_W +: DATA_W];
            gnt_q      <= ONE_HOT0 << sel_d;
            tx_start_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: begin
          last_q  <= sel_q;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            done_q  <= ONE_HOT0 << sel_q;
            state_q <= S_DONE;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LIMIT) begin
            // Transmitter never answered: drop the byte, keep rotation position.
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign arb_busy = busy_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule
